// File: rtl/m31_poseidon2_sponge_if.sv
// Message-in and digest-out handshakes of the M31 Poseidon2 sponge controller.
// The master drives messages and consumes digests; the slave is the sponge itself.
interface m31_poseidon2_sponge_if #(
  parameter int DIGEST_WORDS = 8
);
  logic                      msg_valid;
  logic                      msg_ready;
  logic [30:0]               msg_data;
  logic                      msg_last;
  logic                      digest_valid;
  logic                      digest_ready;
  logic [DIGEST_WORDS*31-1:0] digest_data;

  modport master (
    output msg_valid, msg_data, msg_last, digest_ready,
    input  msg_ready, digest_valid, digest_data
  );

  modport slave (
    input  msg_valid, msg_data, msg_last, digest_ready,
    output msg_ready, digest_valid, digest_data
  );
endinterface

// File: rtl/m31_poseidon2_sponge.sv
// Sponge controller for the fixed-latency, valid-less M31 Poseidon2 permutation pipeline:
// absorbs rate blocks with 10* padding, times each permutation, then presents the digest.
module m31_poseidon2_sponge #(
  parameter int WIDTH        = 16,
  parameter int RATE         = 8,
  parameter int DIGEST_WORDS = 8,
  parameter int PERM_LATENCY = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  m31_poseidon2_sponge_if.slave bus,
  output logic [WIDTH*31-1:0]   perm_state_o,
  input  logic [WIDTH*31-1:0]   perm_state_i
);
  localparam int CW  = $clog2(RATE + 1);
  localparam int WCW = $clog2(PERM_LATENCY + 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'(RATE - 1);
  // perm_state_i shows the result during the PERM_LATENCY-th cycle after launch; sample it on the following edge
  localparam logic [WCW-1:0] WCNT_DONE = WCW'(PERM_LATENCY + 1);
  localparam logic [30:0]    P = 31'h7FFFFFFF;

  typedef enum logic [1:0] {ABSORB, WAIT, PAD, SQUEEZE} fsm_t;

  fsm_t            fsm_q, fsm_d, ret_q, ret_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [30:0]     st_q [WIDTH];
  logic [30:0]     st_d [WIDTH];
  logic [WIDTH*31-1:0] perm_d;
  logic [30:0]     word;
  logic            launch;
  int              slot;

  function automatic logic [30:0] add_mod(input logic [30:0] a, input logic [30:0] b);
    logic [31:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[30:0];
  endfunction

  always_comb begin
    fsm_d  = fsm_q;
    ret_d  = ret_q;
    cnt_d  = cnt_q;
    wcnt_d = wcnt_q;
    st_d   = st_q;
    perm_d = perm_state_o;
    launch = 1'b0;
    word   = (bus.msg_data == P) ? '0 : bus.msg_data;
    slot   = int'(cnt_q);

    unique case (fsm_q)
      ABSORB: begin
        if (bus.msg_valid) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (i == slot) st_d[i] = add_mod(st_q[i], word);
            if (i == slot + 1 && bus.msg_last && cnt_q != CNT_LAST) st_d[i] = add_mod(st_q[i], 31'd1);
          end
          if (bus.msg_last) begin
            launch = 1'b1;
            ret_d  = (cnt_q == CNT_LAST) ? PAD : SQUEEZE;
          end else if (cnt_q == CNT_LAST) begin
            launch = 1'b1;
            ret_d  = ABSORB;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT: begin
        if (wcnt_q == WCNT_DONE) begin
          for (int i = 0; i < WIDTH; i++) st_d[i] = perm_state_i[31*i +: 31];
          fsm_d = ret_q;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      // Message ended exactly on a block boundary: the padding 1 opens a fresh block
      PAD: begin
        st_d[0] = add_mod(st_q[0], 31'd1);
        ret_d   = SQUEEZE;
        launch  = 1'b1;
      end
      SQUEEZE: begin
        if (bus.digest_ready) begin
          for (int i = 0; i < WIDTH; i++) st_d[i] = '0;
          perm_d = '0;
          fsm_d  = ABSORB;
        end
      end
      default: ;
    endcase

    if (launch) begin
      for (int i = 0; i < WIDTH; i++) perm_d[31*i +: 31] = st_d[i];
      wcnt_d = WCW'(1);
      cnt_d  = '0;
      fsm_d  = WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= ABSORB;
      ret_q        <= ABSORB;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      perm_state_o <= '0;
      for (int i = 0; i < WIDTH; i++) st_q[i] <= '0;
    end else begin
      fsm_q        <= fsm_d;
      ret_q        <= ret_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      perm_state_o <= perm_d;
      for (int i = 0; i < WIDTH; i++) st_q[i] <= st_d[i];
    end
  end

  always_comb begin
    bus.msg_ready    = (fsm_q == ABSORB);
    bus.digest_valid = (fsm_q == SQUEEZE);
    bus.digest_data  = '0;
    if (fsm_q == SQUEEZE) begin
      for (int i = 0; i < DIGEST_WORDS; i++) bus.digest_data[31*i +: 31] = st_q[i];
    end
  end
endmodule

// File: tb/tb_m31_poseidon2_sponge.sv
// Scoreboard bench for m31_poseidon2_sponge; the permutation is stubbed by a
// PERM_LATENCY-deep delay line computing out[i] = in[i] + 1 mod p.
module tb_m31_poseidon2_sponge;
  localparam int WIDTH = 16;
  localparam int RATE  = 8;
  localparam int DW    = 8;
  localparam int LAT   = 23;
  localparam logic [30:0] P = 31'h7FFFFFFF;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH*31-1:0] perm_state_o;
  logic [WIDTH*31-1:0] perm_state_i;
  logic [WIDTH*31-1:0] pipe [LAT];

  logic [30:0]         msgQ [$];
  logic [DW*31-1:0]    expQ [$];
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  m31_poseidon2_sponge_if #(.DIGEST_WORDS(DW)) bus ();

  m31_poseidon2_sponge #(
    .WIDTH(WIDTH), .RATE(RATE), .DIGEST_WORDS(DW), .PERM_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .perm_state_o(perm_state_o),
    .perm_state_i(perm_state_i)
  );

  function automatic logic [30:0] addP(input logic [30:0] a, input logic [30:0] b);
    longint s;
    s = (longint'(a) + longint'(b)) % longint'(P);
    return 31'(s);
  endfunction

  function automatic logic [WIDTH*31-1:0] stubPerm(input logic [WIDTH*31-1:0] s);
    logic [WIDTH*31-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[31*i +: 31] = addP(s[31*i +: 31], 31'd1);
    return r;
  endfunction

  // Permutation stub: one register per latency cycle
  always_ff @(posedge clk) begin
    pipe[0] <= stubPerm(perm_state_o);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign perm_state_i = pipe[LAT-1];

  function automatic logic [DW*31-1:0] modelDigest();
    logic [30:0] st [WIDTH];
    logic [DW*31-1:0] d;
    int cnt;
    bit last;
    for (int i = 0; i < WIDTH; i++) st[i] = '0;
    cnt = 0;
    for (int n = 0; n < msgQ.size(); n++) begin
      last = (n == msgQ.size() - 1);
      st[cnt] = addP(st[cnt], msgQ[n]);
      if (last && cnt < RATE - 1) begin
        st[cnt+1] = addP(st[cnt+1], 31'd1);
        for (int i = 0; i < WIDTH; i++) st[i] = addP(st[i], 31'd1);
      end else if (last) begin
        for (int i = 0; i < WIDTH; i++) st[i] = addP(st[i], 31'd1);
        st[0] = addP(st[0], 31'd1);
        for (int i = 0; i < WIDTH; i++) st[i] = addP(st[i], 31'd1);
      end else if (cnt == RATE - 1) begin
        for (int i = 0; i < WIDTH; i++) st[i] = addP(st[i], 31'd1);
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    d = '0;
    for (int i = 0; i < DW; i++) d[31*i +: 31] = st[i];
    return d;
  endfunction

  function automatic logic [DW*31-1:0] packDigest(input logic [30:0] w [DW]);
    logic [DW*31-1:0] d;
    for (int i = 0; i < DW; i++) d[31*i +: 31] = w[i];
    return d;
  endfunction

  function automatic logic [WIDTH*31-1:0] packState(input logic [30:0] w [WIDTH]);
    logic [WIDTH*31-1:0] d;
    for (int i = 0; i < WIDTH; i++) d[31*i +: 31] = w[i];
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sends msgQ (last flag on the final word) with occasional idle gaps; leaves time at accept edge + 1
  task automatic applyStimulus(input bit useFixed, input logic [DW*31-1:0] fixedExp);
    bit accepted;
    expQ.push_back(useFixed ? fixedExp : modelDigest());
    for (int n = 0; n < msgQ.size(); n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.msg_valid = 1'b0;
        bus.msg_data  = 31'($urandom);
        bus.msg_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.msg_valid = 1'b1;
      bus.msg_data  = msgQ[n];
      bus.msg_last  = (n == msgQ.size() - 1);
      accepted = 1'b0;
      for (int t = 0; t < 100 && !accepted; t++) begin
        if (bus.msg_ready) accepted = 1'b1;
        @(posedge clk); #1;
      end
      checkOutput("msg_accept", 512'(accepted), 512'(1));
    end
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    bus.msg_data  = 31'($urandom);
  endtask

  task automatic checkDigest(input int expLatency, input int holdCycles);
    int c;
    logic [DW*31-1:0] exp;
    logic [DW*31-1:0] held;
    c = 0;
    while (!bus.digest_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("digest_valid_rise", 512'(bus.digest_valid), 512'(1));
    if (expLatency >= 0) checkOutput("digest_latency", 512'(c), 512'(expLatency));
    checkOutput("scoreboard_nonempty", 512'(expQ.size() > 0), 512'(1));
    exp = (expQ.size() > 0) ? expQ.pop_front() : '0;
    checkOutput("digest_data", 512'(bus.digest_data), 512'(exp));
    held = bus.digest_data;
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 512'(bus.digest_valid), 512'(1));
      checkOutput("hold_data", 512'(bus.digest_data), 512'(held));
      checkOutput("hold_msg_ready", 512'(bus.msg_ready), 512'(0));
    end
    bus.digest_ready = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready = 1'b0;
    checkOutput("post_msg_ready", 512'(bus.msg_ready), 512'(1));
    checkOutput("post_digest_valid", 512'(bus.digest_valid), 512'(0));
    checkOutput("post_digest_data", 512'(bus.digest_data), 512'(0));
    checkOutput("post_perm_state", 512'(perm_state_o), 512'(0));
  endtask

  initial begin
    logic [30:0] ew [DW];
    logic [30:0] sw [WIDTH];
    int seen;
    int lens [5];

    bus.msg_valid    = 1'b0;
    bus.msg_data     = '0;
    bus.msg_last     = 1'b0;
    bus.digest_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_perm_state", 512'(perm_state_o), 512'(0));
    checkOutput("rst_digest_valid", 512'(bus.digest_valid), 512'(0));
    checkOutput("rst_digest_data", 512'(bus.digest_data), 512'(0));
    checkOutput("rst_msg_ready", 512'(bus.msg_ready), 512'(1));

    $display("[TB] single word with last");
    msgQ = '{31'd5};
    ew = '{31'd6, 31'd2, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1};
    applyStimulus(1'b1, packDigest(ew));
    for (int i = 0; i < WIDTH; i++) sw[i] = '0;
    sw[0] = 31'd5; sw[1] = 31'd1;
    checkOutput("t2_perm_state", 512'(perm_state_o), 512'(packState(sw)));
    checkDigest(24, 0);

    $display("[TB] full block then pad block");
    msgQ = '{31'd1, 31'd2, 31'd3, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8};
    ew = '{31'd4, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8, 31'd9, 31'd10};
    applyStimulus(1'b1, packDigest(ew));
    for (int i = 0; i < WIDTH; i++) sw[i] = (i < RATE) ? 31'(i + 1) : '0;
    checkOutput("t3_perm_state", 512'(perm_state_o), 512'(packState(sw)));
    checkDigest(-1, 0);

    $display("[TB] canonicalisation and modular boundary");
    msgQ = '{31'h7FFFFFFF, 31'h7FFFFFFE, 31'd2};
    ew = '{31'd1, 31'd0, 31'd3, 31'd2, 31'd1, 31'd1, 31'd1, 31'd1};
    applyStimulus(1'b1, packDigest(ew));
    for (int i = 0; i < WIDTH; i++) sw[i] = '0;
    sw[1] = 31'h7FFFFFFE; sw[2] = 31'd2; sw[3] = 31'd1;
    checkOutput("t4_perm_state", 512'(perm_state_o), 512'(packState(sw)));
    checkDigest(24, 0);

    $display("[TB] digest backpressure");
    msgQ = '{31'd9, 31'd10};
    applyStimulus(1'b0, '0);
    checkDigest(-1, 10);

    $display("[TB] reset during wait");
    msgQ = '{31'd5};
    applyStimulus(1'b0, '0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expQ.delete();
    checkOutput("t6_perm_state", 512'(perm_state_o), 512'(0));
    checkOutput("t6_digest_valid", 512'(bus.digest_valid), 512'(0));
    checkOutput("t6_msg_ready", 512'(bus.msg_ready), 512'(1));
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.digest_valid || perm_state_o != '0) seen++;
    end
    checkOutput("t6_no_stale_capture", 512'(seen), 512'(0));
    msgQ = '{31'd5};
    ew = '{31'd6, 31'd2, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1};
    applyStimulus(1'b1, packDigest(ew));
    checkDigest(24, 0);

    $display("[TB] random messages");
    lens = '{7, 9, 16, 17, 1};
    for (int m = 0; m < 5; m++) begin
      msgQ.delete();
      for (int n = 0; n < lens[m]; n++) begin
        case ($urandom_range(0, 3))
          0:       msgQ.push_back(P);
          1:       msgQ.push_back(P - 31'd1);
          default: msgQ.push_back(31'($urandom));
        endcase
      end
      applyStimulus(1'b0, '0);
      checkDigest(-1, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
